// File: rtl/spi_resp_pkg.sv
// Shared types and defaults for the SPI ADC responder.
// Contents: default parameter values, channel count, command field positions,
// and the responder state encoding.
package spi_resp_pkg;

   localparam int unsigned DEF_DATA_W      = 12;
   localparam int unsigned DEF_CMD_W       = 4;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned NUM_CH          = 4;

   // Channel select sits in the two LSBs of the command word; the start bit
   // is always the MSB (CMD_W-1) and SGL sits directly below it.
   localparam int unsigned CMD_CH_HI = 1;
   localparam int unsigned CMD_CH_LO = 0;

   // Field layout of the default 4-bit command word.
   typedef struct packed {
      logic       start;
      logic       sgl;
      logic [1:0] ch;
   } cmd_fields_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_NULL = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for one asynchronous pin plus single-cycle edge pulses.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   pin         : raw asynchronous input
//   level       : synchronised level (registered)
//   rise_c      : one-cycle pulse on a synchronised 0->1 transition
//   fall_c      : one-cycle pulse on a synchronised 1->0 transition
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   localparam int unsigned N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [N-1:0] sync_q, sync_d;
   logic         hist_q, hist_d;

   // Shift chain plus one history flop for edge detection.
   always_comb begin
      sync_d = {sync_q[N-2:0], pin};
      hist_d = sync_q[N-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {N{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level  = sync_q[N-1];
   assign rise_c = sync_q[N-1] & ~hist_q;
   assign fall_c = ~sync_q[N-1] & hist_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder standing in for an ADC: accepts a start/command frame
// on MOSI, then returns a null bit followed by a DATA_W-bit channel sample on
// MISO, MSB first. All pins are oversampled in the Clk domain.
// Optional macro SPI_RESP_PARITY_EN appends an even-parity bit after the data.
// Ports:
//   Clk, Rst        : system clock, synchronous active-high reset
//   SCLK, CS, MOSI  : SPI pins from the initiator (CS active low)
//   MISO            : response data
//   ChanData        : per-channel samples, channel n at [n*DATA_W +: DATA_W]
//   Channel         : channel of the last valid command
//   CmdValid        : one-cycle pulse when a command completes
//   FrameDone       : one-cycle pulse when the final response bit is sampled
//   FrameError      : one-cycle pulse when CS rises mid-frame
//   Busy            : high whenever the responder is not idle
module spi_adc_responder
   import spi_resp_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned CMD_W       = DEF_CMD_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     SCLK,
   input  logic                     CS,
   input  logic                     MOSI,
   output logic                     MISO,
   input  logic [NUM_CH*DATA_W-1:0] ChanData,
   output logic [1:0]               Channel,
   output logic                     CmdValid,
   output logic                     FrameDone,
   output logic                     FrameError,
   output logic                     Busy
);

   localparam int unsigned CNT_W      = $clog2(DATA_W + 2);
   localparam int unsigned SYNC_EFF   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned SETTLE_CNT = SYNC_EFF + 1;
   localparam int unsigned SETTLE_W   = $clog2(SETTLE_CNT + 1);
`ifdef SPI_RESP_PARITY_EN
   localparam int unsigned LAST_CNT   = DATA_W + 1;
`else
   localparam int unsigned LAST_CNT   = DATA_W;
`endif

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_pins;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(Clk), .rst(Rst), .pin(SCLK),
      .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(Clk), .rst(Rst), .pin(CS),
      .level(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(Clk), .rst(Rst), .pin(MOSI),
      .level(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall));

   assign unused_pins = ^{sclk_lvl, mosi_rise, mosi_fall};

   state_e              state_q, state_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d, cmd_shift;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                miso_q, miso_d;
   logic [1:0]          chan_q, chan_d, chan_idx;
   logic                cmd_valid_q, cmd_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                frame_error_q, frame_error_d;
   logic                busy_q, busy_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic                armed_q, armed_d;
`ifdef SPI_RESP_PARITY_EN
   logic                par_q, par_d;
`endif

   logic [DATA_W-1:0] chan_arr [NUM_CH];

   always_comb begin
      for (int n = 0; n < int'(NUM_CH); n++) chan_arr[n] = ChanData[n*DATA_W +: DATA_W];
   end

   // A CS fall is only honoured once CS has been seen high after reset, with
   // the synchroniser flushed so reset values cannot fake a fall.
   always_comb begin
      settle_d = (settle_q == SETTLE_W'(SETTLE_CNT)) ? settle_q : settle_q + SETTLE_W'(1);
      armed_d  = armed_q | ((settle_q == SETTLE_W'(SETTLE_CNT)) & cs_lvl);
   end

   // Responder next-state and output logic.
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      cnt_d         = cnt_q;
      tx_d          = tx_q;
      miso_d        = miso_q;
      chan_d        = chan_q;
      cmd_valid_d   = 1'b0;
      frame_done_d  = 1'b0;
      frame_error_d = 1'b0;
      cmd_shift     = {cmd_q[CMD_W-2:0], mosi_lvl};
      chan_idx      = cmd_shift[CMD_CH_HI:CMD_CH_LO];
`ifdef SPI_RESP_PARITY_EN
      par_d         = par_q;
`endif

      // A CS rise mid-frame takes priority over any SCLK edge in the same cycle.
      if (cs_rise && (state_q inside {ST_CMD, ST_NULL, ST_DATA})) begin
         state_d       = ST_IDLE;
         miso_d        = 1'b0;
         frame_error_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               miso_d = 1'b0;
               if (cs_fall && armed_q) begin
                  state_d = ST_CMD;
                  cmd_d   = '0;
                  cnt_d   = '0;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  if (cmd_q == '0) begin
                     // Zeros before the start bit leave the word empty.
                     cmd_d = CMD_W'(mosi_lvl);
                  end else begin
                     cmd_d = cmd_shift;
                     // Command is complete once the start bit reaches the MSB.
                     if (cmd_shift[CMD_W-1]) begin
                        chan_d      = chan_idx;
                        cmd_valid_d = 1'b1;
                        tx_d        = chan_arr[chan_idx];
`ifdef SPI_RESP_PARITY_EN
                        par_d       = ^chan_arr[chan_idx];
`endif
                        state_d     = ST_NULL;
                     end
                  end
               end
            end
            ST_NULL: begin
               if (sclk_fall) begin
                  miso_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sclk_fall) begin
                  if (cnt_q < CNT_W'(DATA_W)) begin
                     miso_d = tx_q[DATA_W-1];
                     tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                     cnt_d  = cnt_q + CNT_W'(1);
                  end
`ifdef SPI_RESP_PARITY_EN
                  else if (cnt_q == CNT_W'(DATA_W)) begin
                     miso_d = par_q;
                     cnt_d  = cnt_q + CNT_W'(1);
                  end
`endif
               end else if (sclk_rise && (cnt_q == CNT_W'(LAST_CNT))) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_DONE;
               end
            end
            ST_DONE: begin
               if (cs_rise) begin
                  state_d = ST_IDLE;
                  miso_d  = 1'b0;
               end else if (sclk_fall) begin
                  miso_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= ST_IDLE;
         cmd_q         <= '0;
         cnt_q         <= '0;
         tx_q          <= '0;
         miso_q        <= 1'b0;
         chan_q        <= '0;
         cmd_valid_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
         settle_q      <= '0;
         armed_q       <= 1'b0;
`ifdef SPI_RESP_PARITY_EN
         par_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         cnt_q         <= cnt_d;
         tx_q          <= tx_d;
         miso_q        <= miso_d;
         chan_q        <= chan_d;
         cmd_valid_q   <= cmd_valid_d;
         frame_done_q  <= frame_done_d;
         frame_error_q <= frame_error_d;
         busy_q        <= busy_d;
         settle_q      <= settle_d;
         armed_q       <= armed_d;
`ifdef SPI_RESP_PARITY_EN
         par_q         <= par_d;
`endif
      end
   end

   assign MISO       = miso_q;
   assign Channel    = chan_q;
   assign CmdValid   = cmd_valid_q;
   assign FrameDone  = frame_done_q;
   assign FrameError = frame_error_q;
   assign Busy       = busy_q;

endmodule
